// File: rtl/checkpoint_rename_rf_pkg.sv
// Shared types and constants for the checkpointed rename register file:
// default geometry, checkpoint stack entry, and checkpoint command priority.
package rr_pkg;

    localparam int RR_ADDR_W     = 2;
    localparam int RR_NAME_W     = 3;
    localparam int RR_DATA_W     = 32;
    localparam int RR_NUM_ARCH   = 4;
    localparam int RR_NUM_PHYS   = 8;
    localparam int RR_NUM_RD     = 2;
    localparam int RR_NUM_WR     = 2;
    localparam int RR_CKPT_DEPTH = 2;
    localparam int RR_CNT_W      = $clog2(RR_CKPT_DEPTH + 1);

    // One stack slot: the map as it was at save time plus every name allocated since.
    typedef struct packed {
        logic [RR_NUM_ARCH-1:0][RR_NAME_W-1:0] map;
        logic [RR_NUM_PHYS-1:0]                mask;
    } ckpt_entry_t;

    // Encoding doubles as priority: a larger value wins.
    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        CMD_SAVE = 2'd1,
        CMD_REL  = 2'd2,
        CMD_ROLL = 2'd3
    } ck_cmd_t;

    // A raised higher-priority command masks lower ones even when it is itself ignored.
    function automatic ck_cmd_t ck_decode(input logic roll, input logic rel,
                                          input logic save, input logic empty,
                                          input logic full);
        ck_cmd_t cmd;
        if (roll) begin
            cmd = empty ? CMD_NONE : CMD_ROLL;
        end else if (rel) begin
            cmd = empty ? CMD_NONE : CMD_REL;
        end else if (save) begin
            cmd = full ? CMD_NONE : CMD_SAVE;
        end else begin
            cmd = CMD_NONE;
        end
        return cmd;
    endfunction

endpackage

// File: rtl/checkpoint_rename_rf_prio_enc_lsb.sv
// Lowest-set-bit priority encoder used to pick the next free physical name.
module prio_enc_lsb #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         any
);

    logic found_s;

    // Scan upward and latch onto the first request seen.
    always_comb begin
        idx     = {W{1'b0}};
        found_s = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (req[k] && !found_s) begin
                idx     = W'(k);
                found_s = 1'b1;
            end else begin
            end
        end
        any = found_s;
    end

endmodule

// File: rtl/checkpoint_rename_rf.sv
// Rename map with free/busy tracking, forwarding physical register file and a
// small checkpoint stack supporting save, release and rollback.
module checkpoint_rename_rf
    import rr_pkg::*;
#(
    parameter int ADDR_W     = RR_ADDR_W,
    parameter int NAME_W     = RR_NAME_W,
    parameter int DATA_W     = RR_DATA_W,
    parameter int NUM_ARCH   = RR_NUM_ARCH,
    parameter int NUM_PHYS   = RR_NUM_PHYS,
    parameter int NUM_RD     = RR_NUM_RD,
    parameter int NUM_WR     = RR_NUM_WR,
    parameter int CKPT_DEPTH = RR_CKPT_DEPTH
) (
    input  logic                                  CLK,
    input  logic                                  RST,
    input  logic [ADDR_W-1:0]                     ALLOC_ADDR,
    input  logic                                  ALLOC_E,
    output logic                                  ALLOC_READY,
    output logic [NAME_W-1:0]                     ALLOC_NAME,
    input  logic [NUM_RD*ADDR_W-1:0]              RN_ADDR,
    output logic [NUM_RD*NAME_W-1:0]              RN_NAME,
    input  logic [NUM_WR*NAME_W-1:0]              WR_NAME,
    input  logic [NUM_WR*DATA_W-1:0]              WR_DATA,
    input  logic [NUM_WR-1:0]                     WR_E,
    input  logic [NUM_RD*NAME_W-1:0]              RD_NAME,
    output logic [NUM_RD*DATA_W-1:0]              RD_DATA,
    input  logic [NUM_RD*NAME_W-1:0]              VLD_NAME,
    output logic [NUM_RD-1:0]                     VLD_OUT,
    input  logic [NAME_W-1:0]                     FREE_NAME,
    input  logic                                  FREE_E,
    input  logic                                  CK_SAVE,
    input  logic                                  CK_REL,
    input  logic                                  CK_ROLL,
    output logic                                  CK_READY,
    output logic [$clog2(CKPT_DEPTH+1)-1:0]       CK_CNT
);

    localparam int CNT_W = $clog2(CKPT_DEPTH + 1);

    logic [NUM_ARCH-1:0][NAME_W-1:0] map_r, map_n_s;
    logic [NUM_PHYS-1:0][NAME_W-1:0] old_r;
    logic [NUM_PHYS-1:0]             busy_r, busy_n_s, free_r, free_n_s;
    ckpt_entry_t [CKPT_DEPTH-1:0]    ck_r, ck_n_s;
    logic [CNT_W-1:0]                cnt_r, cnt_n_s;
    logic [DATA_W-1:0]               phys_r [NUM_PHYS];

    logic [NAME_W-1:0]   alloc_name_s;
    logic                any_free_s;
    logic                alloc_fire_s;
    logic [NUM_PHYS-1:0] alloc_bit_s;
    ck_cmd_t             cmd_s;
    ckpt_entry_t         top_s;

    prio_enc_lsb #(.N(NUM_PHYS), .W(NAME_W)) u_free_enc (
        .req (free_r),
        .idx (alloc_name_s),
        .any (any_free_s)
    );

    assign ALLOC_NAME   = alloc_name_s;
    assign ALLOC_READY  = any_free_s & ~CK_ROLL;
    assign alloc_fire_s = ALLOC_E & ALLOC_READY;
    assign alloc_bit_s  = alloc_fire_s ? (NUM_PHYS'(1) << alloc_name_s) : {NUM_PHYS{1'b0}};
    assign CK_READY     = (cnt_r < CNT_W'(CKPT_DEPTH));
    assign CK_CNT       = cnt_r;
    assign cmd_s        = ck_decode(CK_ROLL, CK_REL, CK_SAVE,
                                    (cnt_r == {CNT_W{1'b0}}), ~CK_READY);

    // Select the most recently saved checkpoint.
    always_comb begin
        top_s = {$bits(ckpt_entry_t){1'b0}};
        for (int k = 0; k < CKPT_DEPTH; k++) begin
            if (cnt_r == CNT_W'(k + 1)) begin
                top_s = ck_r[k];
            end else begin
            end
        end
    end

    // Next-state of map, free/busy vectors and checkpoint stack.
    always_comb begin
        map_n_s  = map_r;
        free_n_s = free_r;
        busy_n_s = busy_r;
        ck_n_s   = ck_r;
        cnt_n_s  = cnt_r;
        for (int j = 0; j < NUM_WR; j++) begin
            if (WR_E[j]) begin
                busy_n_s[WR_NAME[j*NAME_W +: NAME_W]] = 1'b0;
            end else begin
            end
        end
        if (alloc_fire_s) begin
            busy_n_s[alloc_name_s] = 1'b1;
            free_n_s[alloc_name_s] = 1'b0;
            map_n_s[ALLOC_ADDR]    = alloc_name_s;
        end else begin
        end
        if (FREE_E) begin
            free_n_s[old_r[FREE_NAME]] = 1'b1;
        end else begin
        end
        for (int k = 0; k < CKPT_DEPTH; k++) begin
            if (CNT_W'(k) < cnt_r) begin
                ck_n_s[k].mask = ck_r[k].mask | alloc_bit_s;
            end else begin
            end
        end
        case (cmd_s)
            CMD_SAVE: begin
                // A save in the same cycle as an allocation already owns that name.
                for (int k = 0; k < CKPT_DEPTH; k++) begin
                    if (cnt_r == CNT_W'(k)) begin
                        ck_n_s[k].map  = map_r;
                        ck_n_s[k].mask = alloc_bit_s;
                    end else begin
                    end
                end
                cnt_n_s = cnt_r + CNT_W'(1);
            end
            CMD_REL: begin
                cnt_n_s = cnt_r - CNT_W'(1);
            end
            CMD_ROLL: begin
                map_n_s  = top_s.map;
                free_n_s = free_n_s | top_s.mask;
                busy_n_s = busy_n_s & ~top_s.mask;
                cnt_n_s  = cnt_r - CNT_W'(1);
            end
            default: begin
                cnt_n_s = cnt_r;
            end
        endcase
    end

    // Rename state registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_ARCH; i++) begin
                map_r[i] <= NAME_W'(i);
            end
            for (int i = 0; i < NUM_PHYS; i++) begin
                free_r[i] <= (i >= NUM_ARCH);
                old_r[i]  <= {NAME_W{1'b0}};
            end
            busy_r <= {NUM_PHYS{1'b0}};
            ck_r   <= {(CKPT_DEPTH*$bits(ckpt_entry_t)){1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
        end else begin
            map_r  <= map_n_s;
            free_r <= free_n_s;
            busy_r <= busy_n_s;
            ck_r   <= ck_n_s;
            cnt_r  <= cnt_n_s;
            if (alloc_fire_s) begin
                old_r[alloc_name_s] <= map_r[ALLOC_ADDR];
            end
        end
    end

    // Data array is not reset; later ports overwrite earlier ones on a collision.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (WR_E[j]) begin
                    phys_r[WR_NAME[j*NAME_W +: NAME_W]] <= WR_DATA[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Lookups, forwarded data reads and readiness.
    always_comb begin
        RN_NAME = {(NUM_RD*NAME_W){1'b0}};
        RD_DATA = {(NUM_RD*DATA_W){1'b0}};
        VLD_OUT = {NUM_RD{1'b0}};
        for (int i = 0; i < NUM_RD; i++) begin
            RN_NAME[i*NAME_W +: NAME_W] = map_r[RN_ADDR[i*ADDR_W +: ADDR_W]];
            RD_DATA[i*DATA_W +: DATA_W] = phys_r[RD_NAME[i*NAME_W +: NAME_W]];
            VLD_OUT[i] = ~busy_r[VLD_NAME[i*NAME_W +: NAME_W]];
            // Descending scan so the lowest matching port is the one that sticks.
            for (int j = NUM_WR - 1; j >= 0; j--) begin
                if (WR_E[j] && (WR_NAME[j*NAME_W +: NAME_W] == RD_NAME[i*NAME_W +: NAME_W])) begin
                    RD_DATA[i*DATA_W +: DATA_W] = WR_DATA[j*DATA_W +: DATA_W];
                end else begin
                end
                if (WR_E[j] && (WR_NAME[j*NAME_W +: NAME_W] == VLD_NAME[i*NAME_W +: NAME_W])) begin
                    VLD_OUT[i] = 1'b1;
                end else begin
                end
            end
        end
    end

endmodule

// File: doc/checkpoint_rename_rf.md
CHECKPOINT_RENAME_RF -- requirements
Module: checkpoint_rename_rf

Interface
REQ-001 SHALL have parameter ADDR_W, default 2, meaning architectural register index width.
REQ-002 SHALL have parameter NAME_W, default 3, meaning physical name width.
REQ-003 SHALL have parameter DATA_W, default 32, meaning data width.
REQ-004 SHALL have parameter NUM_ARCH, default 4, meaning architectural register count, less than NUM_PHYS.
REQ-005 SHALL have parameter NUM_PHYS, default 8, meaning physical register count, at most 2^NAME_W.
REQ-006 SHALL have parameter NUM_RD, default 2, meaning read port count.
REQ-007 SHALL have parameter NUM_WR, default 2, meaning write port count.
REQ-008 SHALL have parameter CKPT_DEPTH, default 2, meaning checkpoint stack depth.
REQ-009 SHALL have ports CLK in 1, clock, and RST in 1, reset; reset RST is synchronous, active-high; clock CLK.
REQ-010 SHALL have ports ALLOC_ADDR in ADDR_W, ALLOC_E in 1, ALLOC_READY out 1 and ALLOC_NAME out NAME_W, forming the rename request.
REQ-011 SHALL have ports RN_ADDR in NUM_RD*ADDR_W and RN_NAME out NUM_RD*NAME_W, forming the name lookup.
REQ-012 SHALL have ports WR_NAME in NUM_WR*NAME_W, WR_DATA in NUM_WR*DATA_W and WR_E in NUM_WR, forming the data writes.
REQ-013 SHALL have ports RD_NAME in NUM_RD*NAME_W, RD_DATA out NUM_RD*DATA_W, VLD_NAME in NUM_RD*NAME_W and VLD_OUT out NUM_RD, forming the data and readiness reads.
REQ-014 SHALL have ports FREE_NAME in NAME_W and FREE_E in 1, used to free the name superseded by FREE_NAME.
REQ-015 SHALL have ports CK_SAVE in 1, CK_REL in 1, CK_ROLL in 1, CK_READY out 1 and CK_CNT out clog2(CKPT_DEPTH+1), forming the checkpoint control.

Function
REQ-016 SHALL present ALLOC_NAME as the lowest-index free physical name, combinationally, and ALLOC_READY as (any name free) AND NOT CK_ROLL.
REQ-017 SHALL, on ALLOC_E AND ALLOC_READY, set busy, clear free and record old[name]=map[ALLOC_ADDR], then set map[ALLOC_ADDR]=name at the next edge.
REQ-018 SHALL, on an allocation, also set bit ALLOC_NAME in the alloc mask of every live checkpoint, including one saved in the same cycle.
REQ-019 SHALL read RN_NAME[i]=map[RN_ADDR[i]] combinationally, showing the pre-edge map.
REQ-020 SHALL, for each WR_E[j], write phys[WR_NAME[j]] and clear busy at the edge.
REQ-021 SHALL give RD_DATA[i] by forwarding from the lowest-index j with WR_E[j] and WR_NAME[j]==RD_NAME[i], and otherwise from phys.
REQ-022 SHALL give VLD_OUT[i] = (any enabled WR_NAME[j]==VLD_NAME[i]) OR NOT busy[VLD_NAME[i]].
REQ-023 SHALL, on FREE_E, set free[old[FREE_NAME]].
REQ-024 SHALL, on CK_SAVE AND CK_READY, push a snapshot of the pre-edge map plus an empty alloc mask, and increment CK_CNT; CK_READY = CK_CNT<CKPT_DEPTH.
REQ-025 SHALL, on CK_REL with CK_CNT>0, pop the top entry without restoring and decrement CK_CNT.
REQ-026 SHALL, on CK_ROLL with CK_CNT>0, restore map from the top snapshot, OR its alloc mask into free, clear busy for the masked names, pop, and decrement CK_CNT.
REQ-027 SHALL ignore CK_REL and CK_ROLL when CK_CNT==0, and ignore CK_SAVE when full.
REQ-028 SHALL apply priority CK_ROLL > CK_REL > CK_SAVE within a cycle; a lower-priority checkpoint command is dropped.
REQ-029 SHALL complete writes and FREE_E in a CK_ROLL cycle; the write data lands in phys, and the free and rollback masks are ORed.
REQ-030 SHALL let the highest-index port win when two write ports target the same name at the edge.

Reset
REQ-031 SHALL, while RST is high, set map[i]=i, busy=0, free[i]=(i>=NUM_ARCH) and CK_CNT=0, and ignore all other inputs.
REQ-032 SHALL give outputs after reset of ALLOC_READY=1, ALLOC_NAME=NUM_ARCH, CK_READY=1, and VLD_OUT=1 for any name.
REQ-033 SHALL not reset phys; phys is simulation-initialised to 0.

Structure
REQ-034 SHALL place the parameter-derived widths, the checkpoint entry struct (map snapshot, alloc mask) and the command priority constants in a shared package rr_pkg.
REQ-035 SHALL implement the lowest-free selection as the single sub-module prio_enc_lsb.

Verification
REQ-036 SHALL cover: after reset, alloc r1 -> ALLOC_NAME=4; next cycle RN_NAME(r1)=4 and VLD_OUT(4)=0.
REQ-037 SHALL cover: WR_E[1] name 4 data 0xAB with RD_NAME 4 in the same cycle -> RD_DATA=0xAB and VLD_OUT=1.
REQ-038 SHALL cover: save, alloc r2->4, alloc r3->5, roll -> map r2=2, r3=3, free{4,5}=1, and the next ALLOC_NAME=4.
REQ-039 SHALL cover: save twice, a third save -> ignored (CK_CNT=2); roll, rel, roll -> CK_CNT=0 and the last roll is ignored.
REQ-040 SHALL cover: allocate all 4 spares -> ALLOC_READY=0; FREE_E on name 4 -> the freed old name (r-index) becomes ALLOC_NAME.
REQ-041 SHALL cover: ALLOC_E with CK_ROLL in the same cycle -> allocation suppressed and the map equals the snapshot.
